// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor, LSB first, start/busy/done handshake
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bor
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] part_nxt;
  logic             brw;
  logic             d_bit;
  logic             b_out;

  // Full-subtract cell on the current LSBs; new difference bit enters the partial result from the MSB side
  always_comb begin
    d_bit             = sa[0] ^ sb[0] ^ brw;
    b_out             = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
    part_nxt          = part >> 1;
    part_nxt[WIDTH-1] = d_bit;
  end

  // Control FSM with registered busy/done; diff/bor load only on the completion edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      brw   <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      part  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bor   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            part  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          part <= part_nxt;
          brw  <= b_out;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            diff  <= part_nxt;
            bor   <= b_out;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and random checks of serial_subtractor at WIDTH 8, 1 and 13
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, diff8;
  logic        busy8, done8, bor8;

  logic        start1 = 1'b0;
  logic [0:0]  a1 = '0, b1 = '0, diff1;
  logic        busy1, done1, bor1;

  logic        start13 = 1'b0;
  logic [12:0] a13 = '0, b13 = '0, diff13;
  logic        busy13, done13, bor13;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bor(bor8)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bor(bor1)
  );

  serial_subtractor #(.WIDTH(13)) u13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13),
    .busy(busy13), .done(done13), .diff(diff13), .bor(bor13)
  );

  function automatic logic [31:0] rd_diff(input int w);
    case (w)
      1:       return 32'(diff1);
      13:      return 32'(diff13);
      default: return 32'(diff8);
    endcase
  endfunction

  function automatic logic rd_bor(input int w);
    case (w)
      1:       return bor1;
      13:      return bor13;
      default: return bor8;
    endcase
  endfunction

  function automatic logic rd_busy(input int w);
    case (w)
      1:       return busy1;
      13:      return busy13;
      default: return busy8;
    endcase
  endfunction

  function automatic logic rd_done(input int w);
    case (w)
      1:       return done1;
      13:      return done13;
      default: return done8;
    endcase
  endfunction

  task automatic drive(input int w, input logic [31:0] av, input logic [31:0] bv, input logic st);
    case (w)
      1:       begin a1  = av[0:0];  b1  = bv[0:0];  start1  = st; end
      13:      begin a13 = av[12:0]; b13 = bv[12:0]; start13 = st; end
      default: begin a8  = av[7:0];  b8  = bv[7:0];  start8  = st; end
    endcase
  endtask

  // Issue one operation, scramble operands after acceptance, wait (bounded) for done.
  // Returns at the negedge where done is high.
  task automatic op(input int w, input logic [31:0] av, input logic [31:0] bv,
                    output logic [31:0] d, output logic bo, output int lat,
                    output int nbusy, output bit chg, output bit to);
    logic [31:0] d0;
    @(negedge clk);
    drive(w, av, bv, 1'b1);
    @(negedge clk);
    drive(w, ~av, ~bv, 1'b0);
    d0    = rd_diff(w);
    lat   = 0;
    nbusy = 0;
    chg   = 1'b0;
    to    = 1'b0;
    while (!rd_done(w)) begin
      if (rd_busy(w)) nbusy++;
      if (rd_diff(w) !== d0) chg = 1'b1;
      if (lat >= 60) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    d  = rd_diff(w);
    bo = rd_bor(w);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy8); end
    n_tests++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done8); end
    n_tests++; if (diff8 !== 8'h00) begin n_fail++; $display("FAIL reset_diff got %h want 00", diff8); end
    n_tests++; if (bor8 !== 1'b0) begin n_fail++; $display("FAIL reset_bor got %b want 0", bor8); end
    n_tests++; if ({busy1, done1, bor1, diff1} !== 4'b0) begin n_fail++; $display("FAIL reset_w1 got %b want 0000", {busy1, done1, bor1, diff1}); end
    n_tests++; if ({busy13, done13, bor13, diff13} !== 16'h0) begin n_fail++; $display("FAIL reset_w13 got %h want 0000", {busy13, done13, bor13, diff13}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] av [4] = '{8'h35, 8'h12, 8'h00, 8'hFF};
    logic [7:0] bv [4] = '{8'h12, 8'h35, 8'h01, 8'hFF};
    logic [7:0] ed [4] = '{8'h23, 8'hDD, 8'hFF, 8'h00};
    logic       eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] d;
    logic bo;
    int lat, nb;
    bit chg, to;
    for (int i = 0; i < 4; i++) begin
      op(8, 32'(av[i]), 32'(bv[i]), d, bo, lat, nb, chg, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout vec %0d got no done want done", i); end
      n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL basic_latency vec %0d got %0d want 8", i, lat); end
      n_tests++; if (nb !== 8) begin n_fail++; $display("FAIL basic_busy_cycles vec %0d got %0d want 8", i, nb); end
      n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done vec %0d got %b want 0", i, busy8); end
      n_tests++; if (chg) begin n_fail++; $display("FAIL basic_partial_visible vec %0d got change want stable", i); end
      n_tests++; if (d[7:0] !== ed[i]) begin n_fail++; $display("FAIL basic_diff vec %0d got %h want %h", i, d[7:0], ed[i]); end
      n_tests++; if (bo !== eb[i]) begin n_fail++; $display("FAIL basic_bor vec %0d got %b want %b", i, bo, eb[i]); end
      if (i == 0) begin
        @(negedge clk);
        n_tests++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done8); end
        n_tests++; if (diff8 !== 8'h23) begin n_fail++; $display("FAIL basic_diff_hold got %h want 23", diff8); end
      end
    end
  endtask

  task automatic test_start_held;
    int ndone, last;
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h12; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F;
    ndone = 0;
    last  = -1;
    for (int i = 0; i < 35; i++) begin
      if (done8) begin
        if (ndone == 0) begin
          n_tests++; if (diff8 !== 8'h23 || bor8 !== 1'b0) begin n_fail++; $display("FAIL held_first got %h/%b want 23/0", diff8, bor8); end
        end else begin
          n_tests++; if (diff8 !== 8'hE1 || bor8 !== 1'b0) begin n_fail++; $display("FAIL held_next got %h/%b want e1/0", diff8, bor8); end
          n_tests++; if (i - last !== 10) begin n_fail++; $display("FAIL held_period got %0d want 10", i - last); end
        end
        last = i;
        ndone++;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    n_tests++; if (ndone !== 3) begin n_fail++; $display("FAIL held_done_count got %0d want 3", ndone); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int ndone;
    logic [31:0] d;
    logic bo;
    int lat, nb;
    bit chg, to;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b want 1", busy8); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got busy %b done %b want 0 0", busy8, done8); end
    n_tests++; if (diff8 !== 8'h00 || bor8 !== 1'b0) begin n_fail++; $display("FAIL midrst_out got %h/%b want 00/0", diff8, bor8); end
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d active cycles want 0", ndone); end
    op(8, 32'h80, 32'h01, d, bo, lat, nb, chg, to);
    n_tests++; if (to || d[7:0] !== 8'h7F || bo !== 1'b0) begin n_fail++; $display("FAIL midrst_after got %h/%b want 7f/0", d[7:0], bo); end
  endtask

  task automatic test_width1;
    logic ed [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic eb [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] d;
    logic bo;
    int lat, nb;
    bit chg, to;
    for (int i = 0; i < 4; i++) begin
      op(1, 32'(i >> 1), 32'(i & 1), d, bo, lat, nb, chg, to);
      n_tests++; if (to || lat !== 1 || nb !== 1) begin n_fail++; $display("FAIL w1_timing ab %0d got lat %0d busy %0d want 1 1", i, lat, nb); end
      n_tests++; if (d[0] !== ed[i] || bo !== eb[i]) begin n_fail++; $display("FAIL w1_result ab %0d got %b/%b want %b/%b", i, d[0], bo, ed[i], eb[i]); end
    end
  endtask

  task automatic test_random(input int w);
    logic [31:0] mask, av, bv, ed, d;
    logic eb, bo;
    int lat, nb;
    bit chg, to;
    mask = (32'h1 << w) - 32'h1;
    for (int i = 0; i < 1000; i++) begin
      av = $urandom() & mask;
      bv = $urandom() & mask;
      if (i == 0) begin av = 32'h0; bv = mask; end
      if (i == 1) begin av = mask; bv = 32'h0; end
      ed = (av - bv) & mask;
      eb = (av < bv);
      op(w, av, bv, d, bo, lat, nb, chg, to);
      n_tests++; if (to || lat !== w) begin n_fail++; $display("FAIL rand%0d_latency a %h b %h got %0d want %0d", w, av, bv, lat, w); end
      n_tests++; if (chg) begin n_fail++; $display("FAIL rand%0d_stable a %h b %h got change want stable", w, av, bv); end
      n_tests++; if ((d & mask) !== ed || bo !== eb) begin n_fail++; $display("FAIL rand%0d_result a %h b %h got %h/%b want %h/%b", w, av, bv, d & mask, bo, ed, eb); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_held();
    test_reset_mid_run();
    test_width1();
    test_random(8);
    test_random(13);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
